// File: rtl/game_sequencer.sv
// Runner-game controller: owns gameState, generates the obstacle move tick and step,
// schedules spawns from an LFSR-driven gap counter and keeps a saturating BCD score.
module game_sequencer #(
  parameter int          TICK_DIV  = 199999,
  parameter int          BASE_STEP = 10,
  parameter int          MAX_STEP  = 15,
  parameter int          GAP_MIN   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        collision,
  output logic [2:0]  gameState,
  output logic        move_tick,
  output logic [3:0]  step,
  output logic        spawn,
  output logic [15:0] score,
  output logic [2:0]  level
);

  localparam int                CNT_W   = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV);
  localparam logic [3:0]        STEP0   = 4'(BASE_STEP);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_RUN  = 3'b001,
    ST_OVER = 3'b010
  } state_t;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    bcd_inc_sat = r;
  endfunction

  function automatic logic [3:0] step_for(input logic [2:0] lv);
    logic [4:0] s;
    s = 5'(BASE_STEP) + {2'b00, lv};
    if (s > 5'(MAX_STEP)) begin
      s = 5'(MAX_STEP);
    end else begin
      s = s;
    end
    step_for = s[3:0];
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_gap;
  logic [15:0]        r_lfsr;
  logic               r_start_q;
  logic               r_move_tick;
  logic               r_spawn;
  logic [15:0]        r_score;
  logic [2:0]         r_level;
  logic [3:0]         r_step;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]         w_gap_nxt;
  logic [15:0]        w_score_nxt;
  logic [2:0]         w_level_nxt;
  logic [3:0]         w_step_nxt;
  logic               w_move_tick_nxt;
  logic               w_spawn_nxt;
  logic               w_rise;
  logic [7:0]         w_gap_reload;
  logic [15:0]        w_score_inc;
  logic [2:0]         w_level_inc;

  assign w_rise       = start & ~r_start_q;
  assign w_gap_reload = 8'(GAP_MIN) + {4'b0000, r_lfsr[3:0]};
  assign w_score_inc  = bcd_inc_sat(r_score);
  assign w_level_inc  = (r_level == 3'd7) ? 3'd7 : (r_level + 3'd1);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gap       <= 8'd0;
      r_lfsr      <= LFSR_SEED;
      r_start_q   <= 1'b0;
      r_move_tick <= 1'b0;
      r_spawn     <= 1'b0;
      r_score     <= 16'h0000;
      r_level     <= 3'd0;
      r_step      <= STEP0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_lfsr      <= lfsr_next(r_lfsr);
      r_start_q   <= start;
      r_move_tick <= w_move_tick_nxt;
      r_spawn     <= w_spawn_nxt;
      r_score     <= w_score_nxt;
      r_level     <= w_level_nxt;
      r_step      <= w_step_nxt;
    end
  end

  // Next-state, tick, score/level and spawn scheduling.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gap_nxt       = r_gap;
    w_score_nxt     = r_score;
    w_level_nxt     = r_level;
    w_step_nxt      = r_step;
    w_move_tick_nxt = 1'b0;
    w_spawn_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_RUN;
          w_score_nxt = 16'h0000;
          w_level_nxt = 3'd0;
          w_step_nxt  = STEP0;
          w_gap_nxt   = w_gap_reload;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A collision on the tick edge wins: the tick and everything it carries is dropped.
        if (collision) begin
          w_state_nxt = ST_OVER;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt_nxt       = '0;
          w_move_tick_nxt = 1'b1;
          w_score_nxt     = w_score_inc;
          if ((w_score_inc != r_score) && (w_score_inc[7:0] == 8'h00)) begin
            w_level_nxt = w_level_inc;
            w_step_nxt  = step_for(w_level_inc);
          end else begin
            w_level_nxt = r_level;
          end
          if (r_gap == 8'd0) begin
            w_spawn_nxt = 1'b1;
            w_gap_nxt   = w_gap_reload;
          end else begin
            w_gap_nxt = r_gap - 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_OVER: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OVER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign gameState = r_state;
  assign move_tick = r_move_tick;
  assign spawn     = r_spawn;
  assign score     = r_score;
  assign level     = r_level;
  assign step      = r_step;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: an integer-level game model predicts each cycle's
// outputs into a queue, and an independent monitor compares them against the DUT.
module tb_game_sequencer;

  localparam int          TICK_DIV  = 3;
  localparam int          BASE_STEP = 10;
  localparam int          MAX_STEP  = 15;
  localparam int          GAP_MIN   = 2;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        collision = 1'b0;
  logic [2:0]  gameState;
  logic        move_tick;
  logic [3:0]  step;
  logic        spawn;
  logic [15:0] score;
  logic [2:0]  level;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_DIV(TICK_DIV), .BASE_STEP(BASE_STEP), .MAX_STEP(MAX_STEP),
    .GAP_MIN(GAP_MIN), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .collision(collision),
    .gameState(gameState), .move_tick(move_tick), .step(step),
    .spawn(spawn), .score(score), .level(level)
  );

  typedef struct packed {
    logic [2:0]  gs;
    logic        mt;
    logic        sp;
    logic [15:0] score;
    logic [2:0]  level;
    logic [3:0]  step;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // game model: 0 idle, 1 run, 2 over; score kept as a plain integer
  int          m_state = 0;
  int          m_cnt   = 0;
  int          m_gap   = 0;
  int          m_score = 0;
  logic [15:0] m_lfsr  = SEED;
  bit          m_start_q = 1'b0;
  bit          m_mt = 1'b0;
  bit          m_sp = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit c);
    bit   rise;
    int   reload;
    int   lv;
    exp_t e;
    if (r) begin
      m_state = 0; m_cnt = 0; m_gap = 0; m_score = 0;
      m_lfsr = SEED; m_start_q = 1'b0; m_mt = 1'b0; m_sp = 1'b0;
    end else begin
      rise   = s && !m_start_q;
      reload = GAP_MIN + int'(m_lfsr[3:0]);
      m_mt = 1'b0;
      m_sp = 1'b0;
      if (m_state == 0) begin
        if (rise) begin
          m_state = 1; m_score = 0; m_cnt = 0; m_gap = reload;
        end
      end else if (m_state == 1) begin
        if (c) begin
          m_state = 2; m_cnt = 0;
        end else if (m_cnt == TICK_DIV) begin
          m_cnt = 0;
          m_mt  = 1'b1;
          if (m_score < 9999) m_score++;
          if (m_gap == 0) begin
            m_sp = 1'b1; m_gap = reload;
          end else begin
            m_gap--;
          end
        end else begin
          m_cnt++;
        end
      end else begin
        if (rise) m_state = 0;
      end
      m_start_q = s;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    lv = (m_score / 100 > 7) ? 7 : m_score / 100;
    e.gs    = 3'(m_state);
    e.mt    = m_mt;
    e.sp    = m_sp;
    e.score = to_bcd(m_score);
    e.level = 3'(lv);
    e.step  = 4'((BASE_STEP + lv > MAX_STEP) ? MAX_STEP : BASE_STEP + lv);
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit s, input bit c);
    @(negedge clk);
    reset = r; start = s; collision = c;
    model_step(r, s, c);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops one prediction per clock edge and compares the registered outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gameState", int'(gameState), int'(e.gs));
        chk("move_tick", int'(move_tick), int'(e.mt));
        chk("spawn",     int'(spawn),     int'(e.sp));
        chk("score",     int'(score),     int'(e.score));
        chk("level",     int'(level),     int'(e.level));
        chk("step",      int'(step),      int'(e.step));
        chk("spawn_needs_tick", int'(spawn & ~move_tick), 0);
      end
    end
  end

  initial begin
    int guard;
    int extra;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b1);             // collision in IDLE ignored
    drive(1'b0, 1'b1, 1'b0);                        // start pulse -> RUN
    repeat (24) drive(1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b0);            // held start in RUN ignored
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_cnt != TICK_DIV && guard < 10) begin
      drive(1'b0, 1'b0, 1'b0);
      guard++;
    end
    drive(1'b0, 1'b0, 1'b1);                        // collision on tick edge
    repeat (6) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);                        // OVER -> IDLE
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);                        // IDLE -> RUN, fresh score
    drive(1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_score < 42 && guard < 1000) begin
      drive(1'b0, 1'b0, 1'b0);
      guard++;
    end
    drive(1'b1, 1'b0, 1'b0);                        // reset mid-RUN
    repeat (12) drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0));
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    guard = 0;
    extra = 0;
    while (extra < 3 && guard < 45000) begin          // long run through every level to 9999
      drive(1'b0, ($urandom_range(0, 15) == 0), 1'b0);
      if (m_mt && m_score == 9999) extra++;
      guard++;
    end
    drive(1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
